// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_pkg
//  Description : Shared types and constants for the stacker score engine:
//                FSM state encoding, BCD digit limits, two-digit BCD score
//                type and a BCD magnitude compare helper.
//  Revision    : 1.0  initial release
// ============================================================================
package score_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_OVER    = 2'd2
    } state_t;

    // Packed as {tens, ones} so it lines up with a packed BCD byte.
    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd2_t;

    // Strictly-greater compare on two legal BCD values, tens digit first.
    function automatic logic bcd2_gt(input bcd2_t a, input bcd2_t b);
        if (a.tens != b.tens) begin
            return a.tens > b.tens;
        end
        return a.ones > b.ones;
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_keeper_if.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper_if
//  Description : Game-control and display signals between the game logic
//                (master) and the score engine (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface score_keeper_if;

    logic       start;
    logic       score_inc;
    logic       game_over;
    logic       show_best;
    logic [3:0] value0;
    logic [3:0] value1;
    logic       playing;
    logic       new_best;

    modport master (
        output start, score_inc, game_over, show_best,
        input  value0, value1, playing, new_best
    );

    modport slave (
        input  start, score_inc, game_over, show_best,
        output value0, value1, playing, new_best
    );

endinterface
`default_nettype wire

// File: rtl/bcd2_increment.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2_increment
//  Description : Combinational two-digit BCD +1. At 99 the result either
//                holds at 99 (saturate) or rolls to 00, and o_wrap flags that
//                the input was already at the top of the range.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd2_increment
    import score_pkg::*;
(
    input  bcd2_t i_digits,
    input  logic  i_saturate,
    output bcd2_t o_digits,
    output logic  o_wrap
);

    // Ones digit rolls into tens; only the 99 case needs the saturate select.
    always_comb begin
        o_digits = i_digits;
        o_wrap   = 1'b0;
        if (i_digits.ones != BCD_MAX) begin
            o_digits.ones = i_digits.ones + 4'd1;
        end else if (i_digits.tens != BCD_MAX) begin
            o_digits.ones = '0;
            o_digits.tens = i_digits.tens + 4'd1;
        end else begin
            o_wrap   = 1'b1;
            o_digits = i_saturate ? i_digits : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper
//  Description : Two-digit BCD score engine. Counts rising edges of score_inc
//                while a round is in progress, keeps the best score across
//                rounds and drives the two display digits.
//  Revision    : 1.0  initial release
// ============================================================================
module score_keeper
    import score_pkg::*;
#(
    parameter bit         SATURATE  = 1'b1,
    parameter logic [7:0] BEST_INIT = 8'h00
)(
    input  wire logic     clock,
    input  wire logic     reset,
    score_keeper_if.slave bus
);

    localparam bcd2_t c_BEST_INIT = bcd2_t'(BEST_INIT);

    state_t r_state;
    bcd2_t  r_score;
    bcd2_t  r_best;
    logic   r_inc_q;
    logic   r_new_best;
    logic   r_playing;

    bcd2_t  w_score_next;
    logic   w_wrap;
    logic   w_inc_evt;
    logic   w_score_we;
    bcd2_t  w_display;

    assign w_inc_evt = bus.score_inc & ~r_inc_q;

    bcd2_increment u_inc (
        .i_digits   (r_score),
        .i_saturate (SATURATE),
        .o_digits   (w_score_next),
        .o_wrap     (w_wrap)
    );

    // A saturated counter at 99 has nothing new to write.
    assign w_score_we = ~(w_wrap & SATURATE);

    // Round FSM, edge detector, score and best-score registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_score    <= '0;
            r_best     <= c_BEST_INIT;
            r_inc_q    <= 1'b0;
            r_new_best <= 1'b0;
            r_playing  <= 1'b0;
        end else begin
            // Tracks the level in every state so a held level never re-counts.
            r_inc_q <= bus.score_inc;
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        r_state    <= ST_PLAYING;
                        r_playing  <= 1'b1;
                        r_score    <= '0;
                        r_new_best <= 1'b0;
                    end
                end
                ST_PLAYING: begin
                    // End of round wins over a same-cycle increment.
                    if (bus.game_over) begin
                        r_state   <= ST_OVER;
                        r_playing <= 1'b0;
                        if (bcd2_gt(r_score, r_best)) begin
                            r_best     <= r_score;
                            r_new_best <= 1'b1;
                        end
                    end else if (w_inc_evt && w_score_we) begin
                        r_score <= w_score_next;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_playing <= 1'b0;
                end
            endcase
        end
    end

    assign w_display    = bus.show_best ? r_best : r_score;
    assign bus.value0   = w_display.ones;
    assign bus.value1   = w_display.tens;
    assign bus.playing  = r_playing;
    assign bus.new_best = r_new_best;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Self-checking bench for score_keeper. Two instances share one
//                stimulus stream: a saturating one with best reset to 00 and a
//                wrapping one with best reset to 12. An integer-arithmetic
//                model of the scoring rules is compared every cycle, with
//                literal expectations at the key points of each scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_score_keeper;

    logic clock = 1'b0;
    logic reset, start, score_inc, game_over, show_best;

    always #5 clock = ~clock;

    score_keeper_if bus_s ();
    score_keeper_if bus_w ();

    assign bus_s.start     = start;
    assign bus_s.score_inc = score_inc;
    assign bus_s.game_over = game_over;
    assign bus_s.show_best = show_best;
    assign bus_w.start     = start;
    assign bus_w.score_inc = score_inc;
    assign bus_w.game_over = game_over;
    assign bus_w.show_best = show_best;

    score_keeper #(.SATURATE(1'b1), .BEST_INIT(8'h00)) dut_s (
        .clock (clock), .reset (reset), .bus (bus_s));
    score_keeper #(.SATURATE(1'b0), .BEST_INIT(8'h12)) dut_w (
        .clock (clock), .reset (reset), .bus (bus_w));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (decimal integers) ----------------
    // Index 0 = saturating instance, index 1 = wrapping instance.
    int c_init [2] = '{0, 12};
    bit c_sat  [2] = '{1'b1, 1'b0};
    int m_score[2], m_best[2], m_state[2];   // state: 0 idle, 1 playing, 2 over
    bit m_prev [2], m_nb[2];
    bit m_valid = 1'b0;

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_score[i] = 0; m_best[i] = c_init[i]; m_state[i] = 0;
                m_prev[i] = 1'b0; m_nb[i] = 1'b0;
            end else begin
                bit evt;
                evt = score_inc && !m_prev[i];
                m_prev[i] = score_inc;
                if (m_state[i] != 1 && start) begin
                    m_state[i] = 1; m_score[i] = 0; m_nb[i] = 1'b0;
                end else if (m_state[i] == 1 && game_over) begin
                    m_state[i] = 2;
                    if (m_score[i] > m_best[i]) begin
                        m_best[i] = m_score[i]; m_nb[i] = 1'b1;
                    end
                end else if (m_state[i] == 1 && evt) begin
                    if (m_score[i] == 99) m_score[i] = c_sat[i] ? 99 : 0;
                    else                  m_score[i] = m_score[i] + 1;
                end
            end
        end
        if (reset) m_valid = 1'b1;
    end

    function automatic int shown(input int i);
        return show_best ? m_best[i] : m_score[i];
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("s.value1",   int'(bus_s.value1),   shown(0) / 10);
            chk("s.value0",   int'(bus_s.value0),   shown(0) % 10);
            chk("s.playing",  int'(bus_s.playing),  int'(m_state[0] == 1));
            chk("s.new_best", int'(bus_s.new_best), int'(m_nb[0]));
            chk("w.value1",   int'(bus_w.value1),   shown(1) / 10);
            chk("w.value0",   int'(bus_w.value0),   shown(1) % 10);
            chk("w.playing",  int'(bus_w.playing),  int'(m_state[1] == 1));
            chk("w.new_best", int'(bus_w.new_best), int'(m_nb[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic do_over();
        game_over = 1'b1; tick(); game_over = 1'b0;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            score_inc = 1'b1; tick();
            score_inc = 1'b0; tick();
        end
    endtask

    function automatic int digits(input logic [3:0] tens, input logic [3:0] ones);
        return int'(tens) * 10 + int'(ones);
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1; start = 1'b0; score_inc = 1'b0; game_over = 1'b0; show_best = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state: score 00, best shows BEST_INIT digits.
        chk("rst_score_s", digits(bus_s.value1, bus_s.value0), 0);
        chk("rst_play_s",  int'(bus_s.playing), 0);
        show_best = 1'b1; #1;
        chk("rst_best_w",  digits(bus_w.value1, bus_w.value0), 12);
        show_best = 1'b0;

        // Twelve separate pulses; the first increment is visible one edge later.
        do_start();
        chk("start_play", int'(bus_s.playing), 1);
        score_inc = 1'b1; tick(); score_inc = 1'b0;
        chk("first_inc_latency", digits(bus_s.value1, bus_s.value0), 1);
        tick();
        pulses(11);
        chk("twelve_tens", int'(bus_s.value1), 1);
        chk("twelve_ones", int'(bus_s.value0), 2);
        chk("model_twelve", m_score[0], 12);

        // End at 12: above best 00 on dut_s, equal to best 12 on dut_w.
        do_over();
        chk("over_nb_s",    int'(bus_s.new_best), 1);
        chk("equal_nb_w",   int'(bus_w.new_best), 0);
        chk("over_playing", int'(bus_s.playing), 0);

        // Level held for ten cycles counts once.
        do_start();
        score_inc = 1'b1;
        repeat (10) tick();
        score_inc = 1'b0; tick();
        chk("held_level", digits(bus_s.value1, bus_s.value0), 1);

        // Overflow at 99: saturate vs wrap.
        pulses(98);
        chk("at99_s", digits(bus_s.value1, bus_s.value0), 99);
        chk("at99_w", digits(bus_w.value1, bus_w.value0), 99);
        pulses(1);
        chk("sat_hold", digits(bus_s.value1, bus_s.value0), 99);
        chk("wrap_zero", digits(bus_w.value1, bus_w.value0), 0);
        do_over();
        show_best = 1'b1; #1;
        chk("best99_s", digits(bus_s.value1, bus_s.value0), 99);
        chk("best12_w", digits(bus_w.value1, bus_w.value0), 12);
        show_best = 1'b0;

        // Three-round best-score sequence starting from a fresh best of 00.
        reset = 1'b1; tick(); reset = 1'b0;
        do_start(); pulses(7); do_over();
        chk("r1_nb", int'(bus_s.new_best), 1);
        show_best = 1'b1; #1;
        chk("r1_best", digits(bus_s.value1, bus_s.value0), 7);
        show_best = 1'b0;
        do_start();
        chk("r2_nb_clear", int'(bus_s.new_best), 0);
        pulses(7); do_over();
        chk("r2_nb", int'(bus_s.new_best), 0);
        do_start(); pulses(8); do_over();
        chk("r3_nb", int'(bus_s.new_best), 1);
        show_best = 1'b1; #1;
        chk("r3_best", digits(bus_s.value1, bus_s.value0), 8);
        show_best = 1'b0;

        // game_over and a rising score_inc on the same edge: increment dropped.
        do_start(); pulses(5);
        game_over = 1'b1; score_inc = 1'b1; tick();
        game_over = 1'b0; score_inc = 1'b0; tick();
        chk("over_prio_score", digits(bus_s.value1, bus_s.value0), 5);
        chk("over_prio_play",  int'(bus_s.playing), 0);
        pulses(3);
        chk("over_no_count", digits(bus_s.value1, bus_s.value0), 5);
        start = 1'b1; score_inc = 1'b1; tick(); start = 1'b0; tick(); score_inc = 1'b0;
        chk("held_across_start", digits(bus_s.value1, bus_s.value0), 0);
        tick();

        // Build best 50, then reset mid-round at 34.
        pulses(50); do_over();
        do_start(); pulses(34);
        chk("pre_reset_34", digits(bus_s.value1, bus_s.value0), 34);
        show_best = 1'b1; #1;
        chk("pre_reset_best", digits(bus_s.value1, bus_s.value0), 50);
        show_best = 1'b0;
        reset = 1'b1; score_inc = 1'b1; start = 1'b1; tick();
        reset = 1'b0; score_inc = 1'b0; start = 1'b0;
        chk("mid_reset_score", digits(bus_s.value1, bus_s.value0), 0);
        chk("mid_reset_play",  int'(bus_s.playing), 0);
        chk("mid_reset_nb",    int'(bus_s.new_best), 0);
        show_best = 1'b1; #1;
        chk("mid_reset_best_s", digits(bus_s.value1, bus_s.value0), 0);
        chk("mid_reset_best_w", digits(bus_w.value1, bus_w.value0), 12);
        show_best = 1'b0;

        // IDLE ignores increments and game_over.
        pulses(2); do_over();
        chk("idle_ignore", digits(bus_s.value1, bus_s.value0), 0);
        chk("idle_play",   int'(bus_s.playing), 0);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
